compare_pipe: RTL and testbench

Parametrised, registered successor to the combinational compare block. Takes one operand pair per accepted transfer and evaluates a run-time-selected relation (EQ/NE/LT/LE/GT/GE) in signed or unsigned mode, with WIDTH-bit operands. Also maintains running min/max of operand A and a saturating match counter. Sits between a valid/ready producer and consumer, with one output register stage.

---
 rtl/compare_pipe.sv | 119 +++++++++++
 tb/tb_compare_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/compare_pipe.sv
// compare_pipe
// Registered relational compare stage with valid/ready handshake on both sides.
// Each accepted operand pair (a_i, b_i) is evaluated against the relation in
// op_i (EQ/NE/LT/LE/GT/GE, 6/7 yield 0) in signed or unsigned mode, and the
// result is held in a single output register until the consumer takes it.
// Running min/max of operand A and a saturating count of true results are
// kept alongside.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i, ready_o    input handshake (ready_o combinational from ready_i)
//   a_i, b_i            operands, WIDTH bits
//   op_i, signed_i      relation select and signedness, sampled with the data
//   clear_i             clear running statistics
//   valid_o, ready_i    output handshake
//   q_o                 relation result of the held transfer
//   min_o, max_o        running min/max of accepted a_i
//   stats_valid_o       min_o/max_o hold at least one sample
//   match_cnt_o         saturating count of accepted transfers with q = 1
module compare_pipe #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic [2:0]           op_i,
   input  logic                 signed_i,
   input  logic                 clear_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 q_o,
   output logic [WIDTH-1:0]     min_o,
   output logic [WIDTH-1:0]     max_o,
   output logic                 stats_valid_o,
   output logic [CNT_WIDTH-1:0] match_cnt_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 accept;
   logic                 consume;
   logic                 eq;
   logic                 lt;
   logic                 rel;
   logic                 a_lt_min;
   logic                 a_gt_max;
   logic [CNT_WIDTH-1:0] cnt_base;
   logic [CNT_WIDTH-1:0] cnt_next;

   assign ready_o = !rst_i && (!valid_o || ready_i);
   assign accept  = valid_i && ready_o;
   assign consume = valid_o && ready_i;

   always_comb begin
      eq       = (a_i == b_i);
      lt       = signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
      a_lt_min = signed_i ? ($signed(a_i) < $signed(min_o)) : (a_i < min_o);
      a_gt_max = signed_i ? ($signed(a_i) > $signed(max_o)) : (a_i > max_o);

      rel = 1'b0;
      case (op_i)
         3'd0:    rel = eq;
         3'd1:    rel = !eq;
         3'd2:    rel = lt;
         3'd3:    rel = lt || eq;
         3'd4:    rel = !(lt || eq);
         3'd5:    rel = !lt;
         default: rel = 1'b0;
      endcase

      // A clear in the same cycle as an accept restarts the count before the
      // new sample is included.
      cnt_base = clear_i ? '0 : match_cnt_o;
      cnt_next = cnt_base;
      if (rel && (cnt_base != CNT_MAX)) begin
         cnt_next = cnt_base + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o       <= 1'b0;
         q_o           <= 1'b0;
         min_o         <= '0;
         max_o         <= '0;
         stats_valid_o <= 1'b0;
         match_cnt_o   <= '0;
      end else begin
         if (accept) begin
            q_o     <= rel;
            valid_o <= 1'b1;
         end else if (consume) begin
            valid_o <= 1'b0;
         end

         if (accept) begin
            if (!stats_valid_o || clear_i) begin
               min_o <= a_i;
               max_o <= a_i;
            end else begin
               if (a_lt_min) min_o <= a_i;
               if (a_gt_max) max_o <= a_i;
            end
            stats_valid_o <= 1'b1;
            match_cnt_o   <= cnt_next;
         end else if (clear_i) begin
            min_o         <= '0;
            max_o         <= '0;
            stats_valid_o <= 1'b0;
            match_cnt_o   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_compare_pipe.sv
module tb_compare_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready_i;
   logic [2:0]  op;
   logic        sgn;
   logic        clear;

   logic        valid32;
   logic [31:0] a32, b32;
   logic        ready_o32, valid_o32, q32, stats32;
   logic [31:0] min32, max32;
   logic [15:0] cnt32;

   logic        valid16;
   logic [15:0] a16, b16;
   logic        ready_o16, valid_o16, q16, stats16;
   logic [15:0] min16, max16;
   logic [1:0]  cnt16;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [2:0] SW_OP [11] = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd5, 3'd1};
   localparam logic       SW_S  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic       SW_Q  [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam logic [15:0] ST_A [3]  = '{16'd10, 16'hFFFD, 16'd7};

   always #5 clk = ~clk;

   compare_pipe #(.WIDTH(32), .CNT_WIDTH(16)) dut32 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid32), .ready_o(ready_o32),
      .a_i(a32), .b_i(b32), .op_i(op), .signed_i(sgn), .clear_i(clear),
      .valid_o(valid_o32), .ready_i(ready_i), .q_o(q32),
      .min_o(min32), .max_o(max32), .stats_valid_o(stats32), .match_cnt_o(cnt32)
   );

   compare_pipe #(.WIDTH(16), .CNT_WIDTH(2)) dut16 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid16), .ready_o(ready_o16),
      .a_i(a16), .b_i(b16), .op_i(op), .signed_i(sgn), .clear_i(clear),
      .valid_o(valid_o16), .ready_i(ready_i), .q_o(q16),
      .min_o(min16), .max_o(max16), .stats_valid_o(stats16), .match_cnt_o(cnt16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ready_i = 1'b0; op = 3'd0; sgn = 1'b0; clear = 1'b0;
      valid32 = 1'b0; a32 = '0; b32 = '0;
      valid16 = 1'b0; a16 = '0; b16 = '0;
      step();
      step();

      // reset state
      chk("rst_valid32", 32'(valid_o32), 32'd0);
      chk("rst_q32", 32'(q32), 32'd0);
      chk("rst_min32", min32, 32'd0);
      chk("rst_max32", max32, 32'd0);
      chk("rst_stats32", 32'(stats32), 32'd0);
      chk("rst_cnt32", 32'(cnt32), 32'd0);
      chk("rst_ready32", 32'(ready_o32), 32'd0);
      chk("rst_ready16", 32'(ready_o16), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready32", 32'(ready_o32), 32'd1);

      // signed/unsigned sweep, a=-1/0xFFFFFFFF, b=1, one per cycle
      ready_i = 1'b1;
      valid32 = 1'b1;
      a32 = 32'hFFFF_FFFF;
      b32 = 32'd1;
      for (int i = 0; i < 11; i++) begin
         op  = SW_OP[i];
         sgn = SW_S[i];
         step();
         chk($sformatf("sweep%0d_q", i), 32'(q32), 32'(SW_Q[i]));
         chk($sformatf("sweep%0d_valid", i), 32'(valid_o32), 32'd1);
      end
      valid32 = 1'b0;
      step();
      chk("consume_valid", 32'(valid_o32), 32'd0);
      chk("consume_q_hold", 32'(q32), 32'd1);
      chk("sweep_cnt", 32'(cnt32), 32'd6);
      chk("sweep_min", min32, 32'hFFFF_FFFF);
      chk("sweep_max", max32, 32'hFFFF_FFFF);

      // backpressure
      op = 3'd0; sgn = 1'b0; a32 = 32'd5; b32 = 32'd5; valid32 = 1'b1;
      step();
      chk("bp_first_q", 32'(q32), 32'd1);
      ready_i = 1'b0;
      op = 3'd1; a32 = 32'd7; b32 = 32'd7;
      #1;
      chk("bp_ready_low", 32'(ready_o32), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("bp%0d_q", i), 32'(q32), 32'd1);
         chk($sformatf("bp%0d_valid", i), 32'(valid_o32), 32'd1);
         chk($sformatf("bp%0d_ready", i), 32'(ready_o32), 32'd0);
         chk($sformatf("bp%0d_cnt", i), 32'(cnt32), 32'd7);
      end
      ready_i = 1'b1;
      #1;
      chk("bp_ready_high", 32'(ready_o32), 32'd1);
      step();
      chk("bp_second_q", 32'(q32), 32'd0);
      chk("bp_second_valid", 32'(valid_o32), 32'd1);
      chk("bp_second_cnt", 32'(cnt32), 32'd7);
      valid32 = 1'b0;
      step();

      // statistics, signed then unsigned (WIDTH=16)
      op = 3'd2; sgn = 1'b1; b16 = 16'd0; valid16 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a16 = ST_A[i];
         step();
         if (i == 0) begin
            chk("st_first_min", 32'(min16), 32'd10);
            chk("st_first_max", 32'(max16), 32'd10);
         end
      end
      chk("st_s_min", 32'(min16), 32'h0000_FFFD);
      chk("st_s_max", 32'(max16), 32'd10);
      chk("st_s_valid", 32'(stats16), 32'd1);
      chk("st_s_cnt", 32'(cnt16), 32'd1);

      valid16 = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_min", 32'(min16), 32'd0);
      chk("clr_max", 32'(max16), 32'd0);
      chk("clr_stats", 32'(stats16), 32'd0);
      chk("clr_cnt", 32'(cnt16), 32'd0);
      chk("clr_keeps_valid", 32'(valid_o16), 32'd0);

      sgn = 1'b0; valid16 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a16 = ST_A[i];
         step();
      end
      chk("st_u_min", 32'(min16), 32'd7);
      chk("st_u_max", 32'(max16), 32'h0000_FFFD);
      chk("st_u_cnt", 32'(cnt16), 32'd0);

      // counter saturation with CNT_WIDTH=2
      op = 3'd0; a16 = 16'd3; b16 = 16'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("sat%0d_cnt", i), 32'(cnt16), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      chk("sat_min", 32'(min16), 32'd3);

      // clear together with an accept
      clear = 1'b1; a16 = 16'd42; b16 = 16'd42;
      step();
      clear = 1'b0;
      chk("clracc_min", 32'(min16), 32'd42);
      chk("clracc_max", 32'(max16), 32'd42);
      chk("clracc_cnt", 32'(cnt16), 32'd1);
      chk("clracc_stats", 32'(stats16), 32'd1);
      chk("clracc_q", 32'(q16), 32'd1);

      // reserved ops
      op = 3'd6; a16 = 16'd1; b16 = 16'd1;
      step();
      chk("res6_q", 32'(q16), 32'd0);
      chk("res6_valid", 32'(valid_o16), 32'd1);
      chk("res6_cnt", 32'(cnt16), 32'd1);
      op = 3'd7;
      step();
      chk("res7_q", 32'(q16), 32'd0);
      chk("res7_cnt", 32'(cnt16), 32'd1);

      // reset with a pending result stalled
      op = 3'd0; ready_i = 1'b0; valid16 = 1'b0;
      step();
      chk("pre_rst_valid", 32'(valid_o16), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(ready_o16), 32'd0);
      step();
      chk("mrst_valid", 32'(valid_o16), 32'd0);
      chk("mrst_q", 32'(q16), 32'd0);
      chk("mrst_min", 32'(min16), 32'd0);
      chk("mrst_max", 32'(max16), 32'd0);
      chk("mrst_stats", 32'(stats16), 32'd0);
      chk("mrst_cnt", 32'(cnt16), 32'd0);
      rst = 1'b0;
      #1;
      chk("mrst_ready_after", 32'(ready_o16), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
